uart_tx_arbiter: RTL



---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 20 ++
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter and its round-robin picker.
//   arb_state_t  : arbiter FSM states (IDLE / HDR / XFER).
//   HDR_MARK_OFS : the header marker bit sits at DATA_BIT - HDR_MARK_OFS, which is the MSB.
//   clog2        : constant-evaluable ceiling log2 used to size requester IDs.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int HDR_MARK_OFS = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// AXI-Stream bundle used on both sides of the arbiter.
//   LANES    : number of parallel streams (NUM_REQ on the requester side, 1 on the UART side).
//   DATA_BIT : width of one lane's data.
// Signals: tdata (lane i = bits [i*DATA_BIT +: DATA_BIT]), tvalid, tlast, tready (one bit per lane).
// Handshake: a beat moves on a lane when tvalid & tready are both high at a rising aclk edge;
// the source holds tdata/tlast stable while tvalid is high and tready is low, and tvalid
// never depends on tready.
// Modports: master drives data/valid/last and samples ready; slave is the mirror image.
interface uart_tx_arbiter_if #(
    parameter int LANES    = 1,
    parameter int DATA_BIT = 8
);
    logic [LANES*DATA_BIT-1:0] tdata;
    logic [LANES-1:0]          tvalid;
    logic [LANES-1:0]          tlast;
    logic [LANES-1:0]          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/uart_rr_picker.sv
// Purely combinational round-robin pick.
//   req     in  NUM_REQ : request vector.
//   last_id in  ID_W    : most recently served ID; the search starts at last_id+1 (mod NUM_REQ).
//   next_id out ID_W    : first requesting ID found from that starting point (0 when none).
//   any_req out 1       : at least one request is set.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    next_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest match wins by overwriting.
    always_comb begin
        next_id = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (req[idx]) next_id = idx;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the UART TX stream between NUM_REQ requesters.
// A grant ends on an accepted beat carrying tlast, or on the MAX_BURST-th accepted beat.
// Ports:
//   aclk, aresetn         : clock, synchronous active-low reset.
//   s_axis (slave)        : NUM_REQ requester lanes; only the granted lane sees tready.
//   m_axis (master)       : single lane to the UART TX FIFO (tlast mirrors the granted lane).
//   m_axis_tid            : ID of the granted requester (0 when idle).
//   busy                  : a grant is held.
//   grant_cnt             : beats accepted under the current grant.
//   state_dbg, last_id_dbg: FSM state and round-robin pointer for observation.
// Build option: define UART_ARB_HDR_EN to precede each grant with one header beat
// {marker at MSB, grant ID in the low bits}; the header does not count toward MAX_BURST.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BIT  = 8,
    parameter int MAX_BURST = 16,
    parameter int ID_W      = 2
) (
    input  logic                aclk,
    input  logic                aresetn,
    uart_tx_arbiter_if.slave    s_axis,
    uart_tx_arbiter_if.master   m_axis,
    output logic [ID_W-1:0]     m_axis_tid,
    output logic                busy,
    output logic [7:0]          grant_cnt,
    output arb_state_t          state_dbg,
    output logic [ID_W-1:0]     last_id_dbg
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ID_W-1:0]     pick_id;
    logic                any_req;
    logic                g_valid, g_last, accept, release_g;
    logic [DATA_BIT-1:0] g_data;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req     (s_axis.tvalid),
        .last_id (last_q),
        .next_id (pick_id),
        .any_req (any_req)
    );

    assign g_valid = s_axis.tvalid[grant_q];
    assign g_last  = s_axis.tlast[grant_q];
    assign g_data  = s_axis.tdata[grant_q*DATA_BIT +: DATA_BIT];

    assign accept    = (state_q == XFER) && g_valid && m_axis.tready[0];
    // tlast and the burst cap landing on the same beat still give one release.
    assign release_g = accept && (g_last || (({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST)));

`ifdef UART_ARB_HDR_EN
    logic [DATA_BIT-1:0] hdr_byte;
    assign hdr_byte = (DATA_BIT'(1) << (DATA_BIT - HDR_MARK_OFS)) | DATA_BIT'(grant_q);
`endif

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
`ifdef UART_ARB_HDR_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (m_axis.tready[0]) state_d = XFER;
            end
`endif
            XFER: begin
                if (release_g) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: passthrough of the granted lane while in XFER, idle otherwise.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        s_axis.tready = '0;
        m_axis_tid    = '0;
        busy          = 1'b0;
        case (state_q)
`ifdef UART_ARB_HDR_EN
            HDR: begin
                m_axis.tdata  = hdr_byte;
                m_axis.tvalid = 1'b1;
                m_axis_tid    = grant_q;
                busy          = 1'b1;
            end
`endif
            XFER: begin
                m_axis.tdata           = g_data;
                m_axis.tvalid          = g_valid;
                m_axis.tlast           = g_last;
                s_axis.tready[grant_q] = m_axis.tready[0];
                m_axis_tid             = grant_q;
                busy                   = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_cnt   = cnt_q;
    assign state_dbg   = state_q;
    assign last_id_dbg = last_q;

endmodule
